// File: rtl/led_fade_pkg.sv
// Shared types and elaboration-time helpers for the LED fade/PWM block.
package led_fade_pkg;

    // Per-channel brightness state.
    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } chan_state_t;

    // Full-scale duty for a given counter width; duty at this value is solid on.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Width of the step timer; at least one bit so a 1-cycle step still has a register.
    function automatic int step_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness FSM plus duty register, ramping one LSB per step tick.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                step_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                led_in,
    input  logic                fade_en,
    output logic                pwm_on,
    output logic                ramping
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'(pwm_max(PWM_BITS));

    chan_state_t         state;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;

    // Candidate duty for each direction: one saturating step on step_tick, otherwise hold.
    always_comb begin
        // NOTE: outputs get a default before any condition so no path can infer a latch.
        duty_up = duty;
        duty_dn = duty;
        if (step_tick && (duty != PWM_MAX)) duty_up = duty + 1'b1;
        if (step_tick && (duty != '0))      duty_dn = duty - 1'b1;
    end

    // Brightness FSM: led_in picks the direction first, and a tick in the same cycle
    // steps that way. ON and OFF hold because the step saturates at the rails; a
    // reversal mid-ramp continues from the current duty with no jump.
    always_ff @(posedge sys_clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state <= OFF;
            duty  <= '0;
        end else if (!fade_en) begin
            state <= led_in ? ON : OFF;
            duty  <= led_in ? PWM_MAX : '0;
        end else if (led_in) begin
            state <= (duty_up == PWM_MAX) ? ON : RAMP_UP;
            duty  <= duty_up;
        end else begin
            state <= (duty_dn == '0) ? OFF : RAMP_DOWN;
            duty  <= duty_dn;
        end
    end

    assign pwm_on  = (pwm_cnt < duty);
    assign ramping = (state == RAMP_UP) || (state == RAMP_DOWN);

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage: turns hard on/off LED levels into linear PWM brightness ramps.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int NUM_LED          = 4,
    parameter int PWM_BITS         = 8,
    parameter int FADE_STEP_CYCLES = 392_157
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic [NUM_LED-1:0] led_in,
    input  logic               fade_en,
    output logic [NUM_LED-1:0] led_out,
    output logic               fading
);

    localparam int                  STEP_W    = step_cnt_width(FADE_STEP_CYCLES);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(pwm_max(PWM_BITS) - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FADE_STEP_CYCLES - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic                step_tick;
    logic [NUM_LED-1:0]  pwm_on;
    logic [NUM_LED-1:0]  ramping;

    // PWM carrier counts 0..PWM_MAX-1 so that duty=PWM_MAX is a solid high.
    always_ff @(posedge sys_clk) begin
        if (rst || (pwm_cnt == PWM_LAST)) pwm_cnt <= '0;
        else                              pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Free-running step timer shared by all channels; never restarted by led_in.
    always_ff @(posedge sys_clk) begin
        if (rst || step_tick) step_cnt <= '0;
        else                  step_cnt <= step_cnt + 1'b1;
    end

    assign step_tick = (step_cnt == STEP_LAST);

    for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .sys_clk   (sys_clk),
            .rst       (rst),
            .step_tick (step_tick),
            .pwm_cnt   (pwm_cnt),
            .led_in    (led_in[i]),
            .fade_en   (fade_en),
            .pwm_on    (pwm_on[i]),
            .ramping   (ramping[i])
        );
    end

    // Pin drive and busy flag, registered from the current counter/duty/state values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            led_out <= '0;
            fading  <= 1'b0;
        end else begin
            led_out <= pwm_on;
            fading  <= |ramping;
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm with a small configuration (PWM_MAX=15, 3-cycle step).
module tb_led_fade_pwm;

    localparam int NUM_LED  = 4;
    localparam int PWM_BITS = 4;
    localparam int PWM_MAX  = 15;
    localparam int FADE     = 3;

    logic               sys_clk = 1'b0;
    logic               rst     = 1'b1;
    logic [NUM_LED-1:0] led_in  = '0;
    logic               fade_en = 1'b1;
    logic [NUM_LED-1:0] led_out;
    logic               fading;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    led_fade_pwm #(
        .NUM_LED          (NUM_LED),
        .PWM_BITS         (PWM_BITS),
        .FADE_STEP_CYCLES (FADE)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .led_in  (led_in),
        .fade_en (fade_en),
        .led_out (led_out),
        .fading  (fading)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: each duty moves one step toward its target on every
    // FADE-th cycle since reset (or snaps to it in bypass); the pin is lit when the
    // cycle index modulo PWM_MAX is below the duty; busy means some duty is off target.
    int unsigned     n_edge = 0;
    int              m_duty [NUM_LED];
    int              m_tgt  [NUM_LED];
    logic [NUM_LED-1:0] m_led = '0;
    logic            m_fad  = 1'b0;

    initial begin
        for (int i = 0; i < NUM_LED; i++) begin
            m_duty[i] = 0;
            m_tgt[i]  = 0;
        end
    end

    always @(posedge sys_clk) begin
        logic [NUM_LED-1:0] nxt_led;
        logic               nxt_fad;
        bit                 tick;
        nxt_led = '0;
        nxt_fad = 1'b0;
        for (int i = 0; i < NUM_LED; i++) begin
            nxt_led[i] = (int'(n_edge % PWM_MAX) < m_duty[i]);
            if (m_duty[i] != m_tgt[i]) nxt_fad = 1'b1;
        end
        if (rst) begin
            n_edge = 0;
            for (int i = 0; i < NUM_LED; i++) begin
                m_duty[i] = 0;
                m_tgt[i]  = 0;
            end
            m_led = '0;
            m_fad = 1'b0;
        end else begin
            tick = ((n_edge % FADE) == FADE - 1);
            for (int i = 0; i < NUM_LED; i++) begin
                m_tgt[i] = led_in[i] ? PWM_MAX : 0;
                if (!fade_en)                           m_duty[i] = m_tgt[i];
                else if (tick && m_duty[i] < m_tgt[i])  m_duty[i] = m_duty[i] + 1;
                else if (tick && m_duty[i] > m_tgt[i])  m_duty[i] = m_duty[i] - 1;
            end
            n_edge = n_edge + 1;
            m_led  = nxt_led;
            m_fad  = nxt_fad;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("model_led_out", 32'(led_out), 32'(m_led));
            check("model_fading",  32'(fading),  32'(m_fad));
        end
    end

    initial begin
        int cnt;
        int seg;

        // Reset held for 5 cycles with all targets on: nothing may light or fade.
        rst     = 1'b1;
        led_in  = 4'hF;
        fade_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            chk_en = 1'b1;
            check("reset_led_out", 32'(led_out), 32'h0);
            check("reset_fading",  32'(fading),  32'h0);
        end

        // Full ramp of channel 0 from reset: busy for 44 sampled cycles, then solid on.
        rst    = 1'b0;
        led_in = 4'b0001;
        cnt    = 0;
        repeat (60) begin
            @(negedge sys_clk);
            if (fading) cnt++;
        end
        check("ramp_up_len", 32'(cnt), 32'd44);
        repeat (15) begin
            @(negedge sys_clk);
            check("full_on", 32'(led_out), 32'h1);
        end

        // Reset at full brightness clears the pin on the next edge.
        rst = 1'b1;
        @(negedge sys_clk);
        check("rst_clear_led", 32'(led_out), 32'h0);

        // Reversal at duty 6: ramp back down takes 18 sampled busy cycles.
        rst    = 1'b0;
        led_in = 4'b0001;
        repeat (18) @(negedge sys_clk);
        led_in = 4'b0000;
        cnt    = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (fading) cnt++;
        end
        check("reversal_len", 32'(cnt), 32'd18);

        // Reset mid-ramp with channel 2 at duty 9, then restart from zero.
        rst = 1'b1;
        @(negedge sys_clk);
        rst    = 1'b0;
        led_in = 4'b0100;
        repeat (27) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        check("midramp_rst_led", 32'(led_out), 32'h0);
        check("midramp_rst_fad", 32'(fading),  32'h0);
        rst = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            @(negedge sys_clk);
            check($sformatf("restart_led2_%0d", k), 32'(led_out[2]), (k == 15) ? 32'h1 : 32'h0);
        end

        // Bypass while channel 2 is still ramping: snap to {15,0,15,0}.
        fade_en = 1'b0;
        led_in  = 4'b1010;
        @(negedge sys_clk);
        repeat (20) begin
            @(negedge sys_clk);
            check("bypass_led_out", 32'(led_out), 32'hA);
            check("bypass_fading",  32'(fading),  32'h0);
        end
        fade_en = 1'b1;

        // Randomized segments: new targets, occasional bypass and reset pulses.
        for (int s = 0; s < 120; s++) begin
            led_in  = NUM_LED'($urandom);
            fade_en = ($urandom_range(0, 5) != 0);
            rst     = ($urandom_range(0, 15) == 0);
            @(negedge sys_clk);
            rst = 1'b0;
            seg = $urandom_range(1, 60);
            repeat (seg) @(negedge sys_clk);
        end

        @(negedge sys_clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
